// File: rtl/width_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : width_axil_regs
//  Description : AXI4-Lite slave holding four 32-bit control registers for
//                the width IP. Exposes register contents and a one-cycle
//                write-update strobe per register to the synth fabric.
//  Revision    : 1.0 - initial release
// ============================================================================
module width_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    output logic [3:0]                        reg_wr_pulse_o
);

    localparam int          C_DW         = C_S_AXI_DATA_WIDTH;
    localparam int          C_AW         = C_S_AXI_ADDR_WIDTH;
    localparam int          C_NBYTES     = C_DW / 8;
    localparam logic [1:0]  C_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  C_RESP_SLVERR = 2'b10;

    // Write path state
    logic              aw_held_q, aw_held_d;
    logic [C_AW-1:0]   awaddr_q,  awaddr_d;
    logic              awready_q, awready_d;
    logic              w_held_q,  w_held_d;
    logic [C_DW-1:0]   wdata_q,   wdata_d;
    logic [C_NBYTES-1:0] wstrb_q, wstrb_d;
    logic              wready_q,  wready_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [3:0]        pulse_q,   pulse_d;

    // Read path state
    logic              ar_held_q, ar_held_d;
    logic [C_AW-1:0]   araddr_q,  araddr_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [C_DW-1:0]   rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    // Register file
    logic [C_DW-1:0]   regs_q [4];
    logic [C_DW-1:0]   regs_d [4];

    logic [1:0]        w_aw_idx;
    logic [1:0]        w_ar_idx;
    logic              w_aw_oor;
    logic              w_ar_oor;

    assign w_aw_idx = awaddr_q[3:2];
    assign w_ar_idx = araddr_q[3:2];

    // Address bits above the register window make the access out of range.
    generate
        if (C_AW > 4) begin : g_range_check
            assign w_aw_oor = |awaddr_q[C_AW-1:4];
            assign w_ar_oor = |araddr_q[C_AW-1:4];
        end else begin : g_no_range_check
            assign w_aw_oor = 1'b0;
            assign w_ar_oor = 1'b0;
        end
    endgenerate

    // Protection bits and byte offset carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[1:0], araddr_q[1:0]};

    // Next-state logic for both channels; read and write run independently.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = 4'b0000;
        ar_held_d = ar_held_q;
        araddr_d  = araddr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        regs_d    = regs_q;

        // READY pulses are one cycle wide and blocked while a response is pending.
        awready_d = S_AXI_AWVALID && !aw_held_q && !bvalid_q && !awready_q;
        wready_d  = S_AXI_WVALID  && !w_held_q  && !bvalid_q && !wready_q;
        arready_d = S_AXI_ARVALID && !ar_held_q && !rvalid_q && !arready_q;

        if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end

        // Commit once both halves of the write are held.
        if (aw_held_q && w_held_q && !bvalid_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (w_aw_oor) begin
                bresp_d = C_RESP_SLVERR;
            end else begin
                bresp_d = C_RESP_OKAY;
                for (int b = 0; b < C_NBYTES; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[w_aw_idx][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
                pulse_d[w_aw_idx] = 1'b1;
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (S_AXI_ARVALID && arready_q) begin
            ar_held_d = 1'b1;
            araddr_d  = S_AXI_ARADDR;
        end

        // Read data is taken from the register value before any same-edge commit.
        if (ar_held_q) begin
            ar_held_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = w_ar_oor ? '0 : regs_q[w_ar_idx];
            rresp_d   = w_ar_oor ? C_RESP_SLVERR : C_RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding any in-flight access.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            awready_q <= 1'b0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= C_RESP_OKAY;
            pulse_q   <= 4'b0000;
            ar_held_q <= 1'b0;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= C_RESP_OKAY;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            awready_q <= awready_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            pulse_q   <= pulse_d;
            ar_held_q <= ar_held_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = wready_q;
    assign S_AXI_BVALID   = bvalid_q;
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RVALID   = rvalid_q;
    assign S_AXI_RDATA    = rdata_q;
    assign S_AXI_RRESP    = rresp_q;
    assign reg0_o         = regs_q[0];
    assign reg1_o         = regs_q[1];
    assign reg2_o         = regs_q[2];
    assign reg3_o         = regs_q[3];
    assign reg_wr_pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_width_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_width_axil_regs
//  Description : Self-checking bench for width_axil_regs with a register-file
//                model; uses a 6-bit address so out-of-range decode is reached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_width_axil_regs;

    localparam int C_AW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [C_AW-1:0] S_AXI_AWADDR = '0;
    logic [2:0]      S_AXI_AWPROT = 3'b000;
    logic            S_AXI_AWVALID = 1'b0;
    logic            S_AXI_AWREADY;
    logic [31:0]     S_AXI_WDATA = '0;
    logic [3:0]      S_AXI_WSTRB = '0;
    logic            S_AXI_WVALID = 1'b0;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY = 1'b0;
    logic [C_AW-1:0] S_AXI_ARADDR = '0;
    logic [2:0]      S_AXI_ARPROT = 3'b000;
    logic            S_AXI_ARVALID = 1'b0;
    logic            S_AXI_ARREADY;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY = 1'b0;
    logic [31:0]     reg0_o, reg1_o, reg2_o, reg3_o;
    logic [3:0]      reg_wr_pulse_o;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mdl [4];

    width_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(C_AW)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
        .reg_wr_pulse_o(reg_wr_pulse_o)
    );

    always #5 clk = ~clk;

    // Byte-enable merge: keep old bytes, replace those whose strobe is set.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] mask;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        return (old & ~mask) | (nw & mask);
    endfunction

    // Full write transaction with independent AW/W start delays and B backpressure.
    task automatic axi_write(input logic [C_AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, output logic [1:0] resp, output logic [3:0] pulses,
                             output int pulse_cycles, output int bv_first, output int bv_cycles,
                             output bit timeout);
        bit aw_done = 0, w_done = 0, b_done = 0;
        int cyc = 0, bcnt = 0;
        resp = 2'b11; pulses = 4'b0; pulse_cycles = 0; bv_first = -1; bv_cycles = 0; timeout = 0;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_BREADY = 1'b0;
        while (!b_done) begin
            @(negedge clk);
            if (cyc >= 200) begin timeout = 1; break; end
            if (reg_wr_pulse_o != 4'b0) begin pulses |= reg_wr_pulse_o; pulse_cycles++; end
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
            S_AXI_WVALID = !w_done && cyc >= w_dly;
            if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
            if (S_AXI_BVALID) begin
                if (bv_first < 0) bv_first = cyc;
                bv_cycles++;
                resp = S_AXI_BRESP;
                if (bcnt >= b_dly) begin S_AXI_BREADY = 1'b1; b_done = 1; end
                else bcnt++;
            end
            cyc++;
        end
        @(negedge clk);
        if (reg_wr_pulse_o != 4'b0) begin pulses |= reg_wr_pulse_o; pulse_cycles++; end
        if (S_AXI_BVALID) bv_cycles++;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    endtask

    // Full read transaction with R backpressure; reports whether RDATA/RRESP held steady.
    task automatic axi_read(input logic [C_AW-1:0] addr, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp,
                            output bit stable, output bit timeout);
        bit ar_done = 0, r_done = 0, seen = 0;
        int cyc = 0, rcnt = 0;
        data = 32'hx; resp = 2'bxx; stable = 1; timeout = 0;
        S_AXI_ARADDR = addr; S_AXI_RREADY = 1'b0;
        while (!r_done) begin
            @(negedge clk);
            if (cyc >= 200) begin timeout = 1; break; end
            S_AXI_ARVALID = !ar_done;
            if (S_AXI_ARVALID && S_AXI_ARREADY) ar_done = 1;
            if (S_AXI_RVALID) begin
                if (!seen) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; seen = 1; end
                else if (S_AXI_RDATA !== data || S_AXI_RRESP !== resp) stable = 0;
                if (rcnt >= r_dly) begin S_AXI_RREADY = 1'b1; r_done = 1; end
                else rcnt++;
            end
            cyc++;
        end
        @(negedge clk);
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID} !== 5'b0) begin
            n_err++; $display("FAIL reset_handshakes: got %b expected 00000",
                {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID});
        end
        n_vec++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
            n_err++; $display("FAIL reset_resp_rdata: got %h expected 0", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA});
        end
        n_vec++;
        if ({reg0_o, reg1_o, reg2_o, reg3_o, reg_wr_pulse_o} !== 132'h0) begin
            n_err++; $display("FAIL reset_regs: got %h expected 0", {reg0_o, reg1_o, reg2_o, reg3_o, reg_wr_pulse_o});
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    endtask

    task automatic test_seq_write_read;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc; bit to, st; logic [31:0] rd;
        for (int k = 0; k < 4; k++) begin
            axi_write(C_AW'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0, resp, pl, pc, bf, bc, to);
            mdl[k] = 32'(k + 1);
            n_vec++;
            if (to || resp !== 2'b00 || pl !== 4'(1 << k) || pc != 1 || bc != 1) begin
                n_err++; $display("FAIL seq_write%0d: got to=%0d resp=%b pulse=%b/%0d bvcyc=%0d expected 0 00 %b/1 1",
                    k, to, resp, pl, pc, bc, 4'(1 << k));
            end
            if (k == 0) begin
                n_vec++;
                if (bf != 3) begin n_err++; $display("FAIL write_latency: got %0d expected 3", bf); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            axi_read(C_AW'(4 * k), 0, rd, resp, st, to);
            n_vec++;
            if (to || rd !== 32'(k + 1) || resp !== 2'b00) begin
                n_err++; $display("FAIL seq_read%0d: got %h/%b expected %h/00", k, rd, resp, 32'(k + 1));
            end
        end
    endtask

    task automatic test_order_independence;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc; bit to;
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0, resp, pl, pc, bf, bc, to);
        mdl[2] = 32'hDEADBEEF;
        n_vec++;
        if (to || reg2_o !== 32'hDEADBEEF || bc != 1 || pl !== 4'b0100 || pc != 1) begin
            n_err++; $display("FAIL order_indep: got reg2=%h bvcyc=%0d pulse=%b/%0d expected deadbeef 1 0100/1",
                reg2_o, bc, pl, pc);
        end
    endtask

    task automatic test_strobes;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc; bit to;
        axi_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0, resp, pl, pc, bf, bc, to);
        axi_write(6'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0, resp, pl, pc, bf, bc, to);
        mdl[1] = 32'h11BB33DD;
        n_vec++;
        if (to || reg1_o !== 32'h11BB33DD) begin
            n_err++; $display("FAIL byte_strobe: got %h expected 11bb33dd", reg1_o);
        end
    endtask

    task automatic test_backpressure;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc, cnt; bit to, ok, st, awd, wd;
        logic [31:0] d1, d2, rd;
        d1 = $urandom; d2 = $urandom;
        @(negedge clk);
        S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF; S_AXI_BREADY = 1'b0;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        awd = 0; wd = 0; cnt = 0;
        while (!(awd && wd) && cnt < 50) begin
            if (S_AXI_AWVALID && S_AXI_AWREADY) awd = 1;
            if (S_AXI_WVALID && S_AXI_WREADY) wd = 1;
            @(negedge clk);
            S_AXI_AWVALID = !awd; S_AXI_WVALID = !wd; cnt++;
        end
        cnt = 0;
        while (!S_AXI_BVALID && cnt < 50) begin @(negedge clk); cnt++; end
        mdl[3] = d1;
        S_AXI_AWADDR = 6'h00; S_AXI_WDATA = d2; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(S_AXI_BVALID === 1'b1 && S_AXI_AWREADY === 1'b0 && S_AXI_WREADY === 1'b0)) ok = 0;
        end
        n_vec++;
        if (!ok || S_AXI_BRESP !== 2'b00) begin
            n_err++; $display("FAIL b_stall: got ok=%0d bresp=%b expected 1 00", ok, S_AXI_BRESP);
        end
        n_vec++;
        if (reg3_o !== d1 || reg0_o !== mdl[0]) begin
            n_err++; $display("FAIL b_stall_regs: got %h %h expected %h %h", reg3_o, reg0_o, d1, mdl[0]);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        n_vec++;
        if (S_AXI_BVALID !== 1'b0) begin n_err++; $display("FAIL b_release: got %b expected 0", S_AXI_BVALID); end
        axi_write(6'h00, d2, 4'hF, 0, 0, 0, resp, pl, pc, bf, bc, to);
        mdl[0] = d2;
        n_vec++;
        if (to || reg0_o !== d2 || resp !== 2'b00) begin
            n_err++; $display("FAIL after_stall_write: got %h/%b expected %h/00", reg0_o, resp, d2);
        end
        axi_read(6'h0C, 5, rd, resp, st, to);
        n_vec++;
        if (to || !st || rd !== d1 || resp !== 2'b00) begin
            n_err++; $display("FAIL r_stall: got stable=%0d data=%h resp=%b expected 1 %h 00", st, rd, resp, d1);
        end
    endtask

    task automatic test_collision;
        logic [1:0] wresp, rresp; logic [3:0] pl; int pc, bf, bc; bit to_w, to_r, st;
        logic [31:0] rd, old;
        old = mdl[0];
        fork
            axi_write(6'h00, 32'h55, 4'hF, 0, 0, 0, wresp, pl, pc, bf, bc, to_w);
            axi_read(6'h00, 0, rd, rresp, st, to_r);
        join
        mdl[0] = 32'h55;
        n_vec++;
        if (to_w || to_r || rd !== old || rresp !== 2'b00) begin
            n_err++; $display("FAIL collision_old: got %h expected %h", rd, old);
        end
        axi_read(6'h00, 0, rd, rresp, st, to_r);
        n_vec++;
        if (to_r || rd !== 32'h55) begin n_err++; $display("FAIL collision_new: got %h expected 00000055", rd); end
    endtask

    task automatic test_reset_midop;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc, cnt; bit to, ok;
        @(negedge clk);
        S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1; cnt = 0;
        while (!S_AXI_AWREADY && cnt < 50) begin @(negedge clk); cnt++; end
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (S_AXI_BVALID !== 1'b0 || reg_wr_pulse_o !== 4'b0) ok = 0;
        end
        n_vec++;
        if (!ok || {reg0_o, reg1_o, reg2_o, reg3_o} !== 128'h0) begin
            n_err++; $display("FAIL reset_midop: got ok=%0d regs=%h expected 1 0", ok, {reg0_o, reg1_o, reg2_o, reg3_o});
        end
        axi_write(6'h04, 32'hCAFE0001, 4'hF, 0, 0, 0, resp, pl, pc, bf, bc, to);
        mdl[1] = 32'hCAFE0001;
        n_vec++;
        if (to || resp !== 2'b00 || reg1_o !== 32'hCAFE0001 || pl !== 4'b0010 || bc != 1) begin
            n_err++; $display("FAIL post_reset_write: got %h/%b/%b expected cafe0001/00/0010", reg1_o, resp, pl);
        end
    endtask

    task automatic test_out_of_range;
        logic [1:0] resp; logic [3:0] pl; int pc, bf, bc; bit to, st; logic [31:0] rd;
        axi_write(6'h14, 32'h12345678, 4'hF, 0, 1, 0, resp, pl, pc, bf, bc, to);
        n_vec++;
        if (to || resp !== 2'b10 || pc != 0 || {reg0_o, reg1_o, reg2_o, reg3_o} !== {mdl[0], mdl[1], mdl[2], mdl[3]}) begin
            n_err++; $display("FAIL oor_write: got resp=%b pulses=%0d expected 10 0 and regs unchanged", resp, pc);
        end
        axi_read(6'h27, 0, rd, resp, st, to);
        n_vec++;
        if (to || rd !== 32'h0 || resp !== 2'b10) begin
            n_err++; $display("FAIL oor_read: got %h/%b expected 00000000/10", rd, resp);
        end
        axi_read(6'h07, 0, rd, resp, st, to);
        n_vec++;
        if (to || rd !== mdl[1] || resp !== 2'b00) begin
            n_err++; $display("FAIL low_bits_ignored: got %h/%b expected %h/00", rd, resp, mdl[1]);
        end
    endtask

    task automatic test_random;
        logic [1:0] resp, eresp; logic [3:0] pl, strb; int pc, bf, bc, idx; bit to, st, oor;
        logic [31:0] d, rd, exp_d; logic [C_AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 3);
            oor = ($urandom_range(0, 7) == 0);
            a = {oor ? 2'($urandom_range(1, 3)) : 2'b00, 2'(idx), 2'($urandom_range(0, 3))};
            eresp = oor ? 2'b10 : 2'b00;
            if ($urandom_range(0, 2) != 0) begin
                d = $urandom; strb = 4'($urandom);
                axi_write(a, d, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                          resp, pl, pc, bf, bc, to);
                if (!oor) mdl[idx] = merge(mdl[idx], d, strb);
                n_vec++;
                if (to || resp !== eresp || pl !== (oor ? 4'b0 : 4'(1 << idx)) || pc != (oor ? 0 : 1)
                    || {reg0_o, reg1_o, reg2_o, reg3_o} !== {mdl[0], mdl[1], mdl[2], mdl[3]}) begin
                    n_err++; $display("FAIL rand_write%0d: addr=%h resp=%b pulse=%b regs=%h expected %b %b %h",
                        n, a, resp, pl, {reg0_o, reg1_o, reg2_o, reg3_o}, eresp,
                        oor ? 4'b0 : 4'(1 << idx), {mdl[0], mdl[1], mdl[2], mdl[3]});
                end
            end else begin
                exp_d = oor ? 32'h0 : mdl[idx];
                axi_read(a, $urandom_range(0, 3), rd, resp, st, to);
                n_vec++;
                if (to || !st || rd !== exp_d || resp !== eresp) begin
                    n_err++; $display("FAIL rand_read%0d: addr=%h got %h/%b expected %h/%b", n, a, rd, resp, exp_d, eresp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq_write_read();
        test_order_independence();
        test_strobes();
        test_backpressure();
        test_collision();
        test_reset_midop();
        test_out_of_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/width_axil_regs.md
Name: width_axil_regs

Overview:
- AXI4-Lite slave (responder) exposing four 32-bit read/write control registers to the PS-side AXI master.
- Acts as the register front end of the width IP in the additive synth datapath.
- Presents register contents and one-cycle write-update strobes to the synth fabric.
- The existing master-VIP bench writes 0x1..0x4 to offsets 0x0..0xC and reads them back; this block is the slave end of that exchange.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; must be >= 4.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH / S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1
- reg0_o, reg1_o, reg2_o, reg3_o  out  32 each  current register values
- reg_wr_pulse_o  out  4  bit k pulses high for one cycle when register k is written

Behaviour:
- Reset (sampled on rising edge while S_AXI_ARESET=1):
  - all READY/VALID outputs 0; BRESP=RRESP=00; RDATA=0;
  - reg0..reg3 = 0; reg_wr_pulse_o = 0;
  - internal held flags cleared.
  - Reset mid-transaction discards any captured AW/W/AR; no B or R response is issued for it.
- Decode:
  - register index = addr[3:2];
  - addr[1:0] ignored;
  - if C_S_AXI_ADDR_WIDTH>4 and addr[ADDR_WIDTH-1:4]!=0, the access is out of range.
- Write channel acceptance:
  - AW and W are captured independently, in either order.
  - AWREADY is a registered one-cycle pulse, asserted in cycle N+1 when, at edge N: AWVALID=1, aw_held=0, BVALID=0, AWREADY=0. Address is latched and aw_held set on that handshake.
  - WREADY follows the same rule with WVALID/w_held, latching WDATA/WSTRB.
- Write commit:
  - In the cycle where aw_held & w_held = 1 and BVALID = 0, commit at the next edge:
    - register bytes updated only where WSTRB[b]=1;
    - reg_wr_pulse_o[idx] high for exactly that following cycle;
    - BVALID set with BRESP=00 (OKAY), or BRESP=10 (SLVERR) with no register change and no pulse when out of range;
    - held flags cleared.
  - BVALID and BRESP hold until the BREADY handshake, then BVALID goes 0.
  - No new AW/W is accepted while BVALID=1 (at most one write outstanding).
  - Latency with AW and W both valid at edge 0 and BREADY tied 1: READYs high in cycle 1, commit at edge 2, BVALID high in cycle 3 for 1 cycle.
- Read:
  - ARREADY is a registered one-cycle pulse in cycle N+1 when, at edge N: ARVALID=1, ARREADY=0, RVALID=0. The address is latched.
  - At the next edge: RVALID=1, RDATA = register[idx] value at that edge (pre-commit if a write commits on the same edge); RRESP=00.
  - Out of range: RDATA=0, RRESP=10.
  - RVALID and RDATA are held stable until RREADY; at most one read outstanding.
  - Read and write paths operate concurrently with no arbitration.
- BREADY/RREADY held low indefinitely: the block stalls and accepts nothing further on that channel; the other channel is unaffected.

Test Plan:
- Sequential write/read: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, WSTRB=F, then read each back → RDATA 0x1..0x4, all RESP=00; reg_wr_pulse_o pulses 0001,0010,0100,1000 once each.
- Order independence: WVALID 3 cycles before AWVALID, addr 0x8, data 0xDEADBEEF → single commit, reg2_o=0xDEADBEEF, exactly one BVALID.
- Byte strobes: reg1=0x11223344, write 0xAABBCCDD with WSTRB=0101 → reg1_o=0x11BB33DD.
- Backpressure: hold BREADY=0 for 10 cycles after a write → BVALID stays 1, AWREADY/WREADY stay 0 for a second write until B completes; RREADY=0 for 5 cycles → RDATA stable.
- Write/read collision: read 0x0 and commit of 0x55 to 0x0 on the same edge → RDATA returns the old value; a subsequent read returns 0x55.
- Reset mid-op: assert S_AXI_ARESET after AW captured but before W → no BVALID, all regs 0; a following full write succeeds normally.
